alu_result_collector: RTL and testbench
=======================================

# alu_result_collector

Parametrised successor to the ALU output mux. It accepts an opcode-tagged issue and waits for the selected functional unit (parity, popcount, rotr, rotl, plus any added units) to assert its result-valid. It captures that unit's result into an output FIFO and presents it downstream on a valid/ready handshake. Illegal opcodes and units that never respond produce an all-zero result flagged with an error code instead of hanging the pipeline.

## Interface
- `DATA_WIDTH`, 1024, width of each functional-unit result and of `out_data`
- `NUM_OPS`, 4, number of functional-unit channels; opcode `i` selects channel `i`
- `OP_W`, 3, opcode width; must satisfy `2**OP_W >= NUM_OPS`
- `FIFO_DEPTH`, 2, output FIFO entries; power of two, ≥2
- `TIMEOUT`, 64, WAIT cycles before a missing unit result is abandoned; ≥2

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `issue_valid`  in  1  opcode offered
- `issue_ready`  out  1  collector can accept an opcode
- `issue_opcode`  in  `OP_W`  operation tag
- `fu_valid`  in  `NUM_OPS`  per-channel result-valid, level
- `fu_data`  in  `NUM_OPS*DATA_WIDTH`  channel `i` occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  downstream accepts head
- `out_data`  out  `DATA_WIDTH`  result
- `out_opcode`  out  `OP_W`  opcode tag of the head entry
- `out_err`  out  2  `{timeout, illegal}` of the head entry; `00` = good result

## Operation
- States: IDLE, WAIT, FLUSH.
- IDLE: `issue_ready = !fifo_full`. An issue handshake latches the opcode.
  - If `opcode < NUM_OPS`: go to WAIT and clear the timeout counter.
  - Otherwise: go to FLUSH.
- WAIT: `issue_ready = 0`. Each cycle:
  - If `fu_valid[op]` is high: push `{op, fu_data[op], 2'b00}`, then return to IDLE.
  - Else if the counter equals `TIMEOUT-1`: push `{op, 0, 2'b10}`, then return to IDLE.
  - Else: increment the counter.
- FLUSH: push `{op, 0, 2'b01}`, then return to IDLE (one cycle).
- `fu_valid` on non-selected channels is ignored in every state.
- Only one operation is in flight. Because issue is gated on `!fifo_full`, a push never overflows; no backpressure path exists in WAIT or FLUSH.
- FIFO behaviour:
  - Pop when `out_valid && out_ready`.
  - `out_valid = (count != 0)`; `out_*` are driven from the head register.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `out_data`/`out_err`/`out_opcode` remain stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, counter 0, FIFO empty. Outputs: `issue_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_opcode = 0`, `out_err = 00`.
- Assertion of `rst_n` mid-operation discards the in-flight op and all FIFO entries immediately.
- Issue edge T. If `fu_valid[op]` is high in the cycle after T, the push occurs at edge T+1 and `out_valid` is high after T+1. Minimum latency is 2 edges from issue to the `out_valid`-visible edge.
- Illegal opcode: push at T+1, `out_valid` high after T+1.
- Timeout: push at edge T+`TIMEOUT`.
- `issue_ready` returns high the cycle after the push if the FIFO is not full. Back-to-back throughput is one op per 2 cycles.
- `fu_valid` asserted in the same cycle as the issue handshake is not sampled; the first sample is in WAIT.

## Structure
- Shared package `alu_pkg`:
  - opcode constants PARITY=0, POPCOUNT=1, ROTR=2, ROTL=3
  - state encoding
  - `out_err` bit positions `ERR_ILLEGAL = 0`, `ERR_TIMEOUT = 1`
- Sub-module `result_fifo`: parametrised by entry width and depth; synchronous push/pop; exposes `full`, `empty`, and head.

## Test plan
- Issue opcode 1, drive `fu_valid = 4'b0010` with `fu_data` ch1 = `0x5A` one cycle later → `out_valid` asserted, `out_data = 0x5A`, `out_opcode = 1`, `out_err = 00`. Hold `out_ready = 0` for 3 cycles → outputs stable.
- Issue opcode 2 while only `fu_valid[0]` and `fu_valid[3]` pulse → no output. At edge T+64 push `out_data = 0`, `out_err = 10`, `out_opcode = 2`.
- Issue opcode 5 (`NUM_OPS = 4`) → one cycle later `out_data = 0`, `out_err = 01`, `out_opcode = 5`.
- `out_ready = 0`, issue two legal ops that complete (`FIFO_DEPTH = 2`) → `issue_ready` low. Pop once → `issue_ready` high next cycle. Entries drain in issue order.
- Pull `rst_n` low during WAIT with one entry queued → `out_valid = 0` and `issue_ready = 1` immediately. A late `fu_valid` after release produces no output.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result collector: opcode tags, FSM states, error bits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // Functional-unit opcode tags; opcode i selects result channel i
    localparam int PARITY   = 0;
    localparam int POPCOUNT = 1;
    localparam int ROTR     = 2;
    localparam int ROTL     = 3;

    // Bit positions inside the 2-bit error field {timeout, illegal}
    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_TIMEOUT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO with a registered head; holds collected ALU results.
// Latency: a push is visible at the head one edge later when the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; full/empty exported.
module result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_dat_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_vld_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
// Collects one opcode-selected functional-unit result per issue into an output FIFO.
// Latency: 2 edges issue-to-out_valid when the unit answers at once; TIMEOUT edges if it never does.
// Backpressure: issue_ready drops while busy or while the FIFO is full; out_valid/out_ready on the head.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int NUM_OPS    = 4,
    parameter int OP_W       = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [OP_W-1:0]               issue_opcode,
    input  logic [NUM_OPS-1:0]            fu_valid,
    input  logic [NUM_OPS*DATA_WIDTH-1:0] fu_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [OP_W-1:0]               out_opcode,
    output logic [1:0]                    out_err
);

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [DATA_WIDTH-1:0] dat;
        logic [1:0]            err;
    } entry_t;

    localparam int             CNT_W   = $clog2(TIMEOUT);
    localparam logic [OP_W:0]  OPS_LIM = (OP_W + 1)'(NUM_OPS);

    state_t                state_q;
    logic [OP_W-1:0]       op_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  sel_vld;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  push_vld;
    entry_t                push_ent;
    entry_t                head_ent;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  issue_fire;
    logic                  op_legal;

    assign issue_ready = (state_q == ST_IDLE) && !fifo_full;
    assign issue_fire  = issue_valid && issue_ready;
    assign op_legal    = ({1'b0, issue_opcode} < OPS_LIM);

    // Pick the latched opcode's channel; every other channel is ignored
    always_comb begin
        sel_vld = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (op_q == OP_W'(i)) begin
                sel_vld = fu_valid[i];
                sel_dat = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Build the FIFO entry: real result, timeout marker or illegal-opcode marker
    always_comb begin
        push_vld     = 1'b0;
        push_ent     = '0;
        push_ent.op  = op_q;
        case (state_q)
            ST_WAIT: begin
                if (sel_vld) begin
                    push_vld     = 1'b1;
                    push_ent.dat = sel_dat;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    push_vld                  = 1'b1;
                    push_ent.err[ERR_TIMEOUT] = 1'b1;
                end
            end
            ST_FLUSH: begin
                push_vld                  = 1'b1;
                push_ent.err[ERR_ILLEGAL] = 1'b1;
            end
            default: begin
                push_vld = 1'b0;
            end
        endcase
    end

    // Control FSM: one op in flight, timeout counter only runs while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_fire) begin
                        op_q    <= issue_opcode;
                        cnt_q   <= '0;
                        state_q <= op_legal ? ST_WAIT : ST_FLUSH;
                    end
                end
                ST_WAIT: begin
                    if (push_vld) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Issue is gated on !full, so a push can never be dropped here
    result_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_vld_i (push_vld),
        .push_dat_i (push_ent),
        .pop_i      (out_valid && out_ready),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (head_ent)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = head_ent.dat;
    assign out_opcode = head_ent.op;
    assign out_err    = head_ent.err;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector: fast result, timeout, illegal opcode, full FIFO, reset.
module tb_alu_result_collector;
    import alu_pkg::*;

    localparam int DW   = 1024;
    localparam int NOPS = 4;
    localparam int OPW  = 3;
    localparam int FD   = 2;
    localparam int TO   = 64;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [OPW-1:0]       issue_opcode;
    logic [NOPS-1:0]      fu_valid;
    logic [NOPS*DW-1:0]   fu_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [OPW-1:0]       out_opcode;
    logic [1:0]           out_err;

    int n_checks = 0;
    int n_errs   = 0;
    logic early;

    always #5 clk = ~clk;

    alu_result_collector #(
        .DATA_WIDTH (DW),
        .NUM_OPS    (NOPS),
        .OP_W       (OPW),
        .FIFO_DEPTH (FD),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_opcode (issue_opcode),
        .fu_valid     (fu_valid),
        .fu_data      (fu_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_opcode   (out_opcode),
        .out_err      (out_err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [DW-1:0] v);
        fu_data[ch*DW +: DW] = v;
    endtask

    initial begin
        rst_n        = 1'b0;
        issue_valid  = 1'b0;
        issue_opcode = '0;
        fu_valid     = '0;
        fu_data      = '0;
        out_ready    = 1'b0;
        early        = 1'b0;
        #1;
        chk("rst_issue_ready", DW'(issue_ready), DW'(1));
        chk("rst_out_valid",   DW'(out_valid),   DW'(0));
        chk("rst_out_data",    out_data,         DW'(0));
        chk("rst_out_opcode",  DW'(out_opcode),  DW'(0));
        chk("rst_out_err",     DW'(out_err),     DW'(0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Fast result on POPCOUNT channel, then hold the head with out_ready low
        issue_valid  = 1'b1;
        issue_opcode = OPW'(POPCOUNT);
        chk("t1_ready_before", DW'(issue_ready), DW'(1));
        step();
        issue_valid = 1'b0;
        fu_valid    = 4'b0010;
        set_ch(1, DW'('h5A));
        chk("t1_no_out_yet", DW'(out_valid),   DW'(0));
        chk("t1_busy",       DW'(issue_ready), DW'(0));
        step();
        fu_valid = '0;
        chk("t1_valid",  DW'(out_valid),  DW'(1));
        chk("t1_data",   out_data,        DW'('h5A));
        chk("t1_opcode", DW'(out_opcode), DW'(1));
        chk("t1_err",    DW'(out_err),    DW'(0));
        chk("t1_ready_after", DW'(issue_ready), DW'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_hold_valid", DW'(out_valid), DW'(1));
            chk("t1_hold_data",  out_data,       DW'('h5A));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drained", DW'(out_valid), DW'(0));

        // ROTR never answers while neighbouring channels pulse -> timeout entry
        issue_valid  = 1'b1;
        issue_opcode = OPW'(ROTR);
        fu_valid     = 4'b1001;
        set_ch(2, DW'('h77));
        step();
        issue_valid = 1'b0;
        for (int k = 1; k < TO; k++) begin
            fu_valid = k[0] ? 4'b1001 : 4'b0000;
            step();
            if (out_valid) early = 1'b1;
        end
        fu_valid = '0;
        chk("t2_no_early_out", DW'(early), DW'(0));
        step();
        chk("t2_valid",  DW'(out_valid),  DW'(1));
        chk("t2_data",   out_data,        DW'(0));
        chk("t2_err",    DW'(out_err),    DW'(2'b10));
        chk("t2_opcode", DW'(out_opcode), DW'(2));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t2_drained", DW'(out_valid), DW'(0));

        // Illegal opcode 5 -> flushed one cycle later with the illegal flag
        issue_valid  = 1'b1;
        issue_opcode = 3'd5;
        step();
        issue_valid = 1'b0;
        chk("t3_no_out_yet", DW'(out_valid), DW'(0));
        step();
        chk("t3_valid",  DW'(out_valid),  DW'(1));
        chk("t3_data",   out_data,        DW'(0));
        chk("t3_err",    DW'(out_err),    DW'(2'b01));
        chk("t3_opcode", DW'(out_opcode), DW'(5));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Fill the FIFO with two results, confirm issue stalls, then drain in order
        issue_valid  = 1'b1;
        issue_opcode = OPW'(PARITY);
        step();
        issue_valid = 1'b0;
        fu_valid    = 4'b0001;
        set_ch(0, DW'('hAA));
        step();
        fu_valid     = '0;
        chk("t4_ready_one_entry", DW'(issue_ready), DW'(1));
        issue_valid  = 1'b1;
        issue_opcode = OPW'(ROTL);
        step();
        issue_valid = 1'b0;
        fu_valid    = 4'b1000;
        set_ch(3, DW'('h33));
        step();
        fu_valid     = '0;
        issue_valid  = 1'b1;
        issue_opcode = 3'd1;
        chk("t4_full_ready", DW'(issue_ready), DW'(0));
        step();
        step();
        chk("t4_still_full", DW'(issue_ready), DW'(0));
        chk("t4_head_data",  out_data,         DW'('hAA));
        chk("t4_head_op",    DW'(out_opcode),  DW'(0));
        issue_valid = 1'b0;
        out_ready   = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_ready_after_pop", DW'(issue_ready), DW'(1));
        chk("t4_second_data",     out_data,         DW'('h33));
        chk("t4_second_op",       DW'(out_opcode),  DW'(3));
        chk("t4_second_err",      DW'(out_err),     DW'(0));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_empty", DW'(out_valid), DW'(0));

        // Reset during WAIT with one entry queued
        issue_valid  = 1'b1;
        issue_opcode = OPW'(PARITY);
        step();
        issue_valid = 1'b0;
        fu_valid    = 4'b0001;
        set_ch(0, DW'('h11));
        step();
        fu_valid     = '0;
        issue_valid  = 1'b1;
        issue_opcode = OPW'(POPCOUNT);
        step();
        issue_valid = 1'b0;
        chk("t5_queued", DW'(out_valid), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", DW'(out_valid),   DW'(0));
        chk("t5_rst_ready", DW'(issue_ready), DW'(1));
        chk("t5_rst_data",  out_data,         DW'(0));
        step();
        step();
        rst_n    = 1'b1;
        fu_valid = 4'b0010;
        set_ch(1, DW'('h99));
        step();
        step();
        step();
        chk("t5_late_fu_ignored", DW'(out_valid),   DW'(0));
        chk("t5_ready_idle",      DW'(issue_ready), DW'(1));
        fu_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
